// File: rtl/ring_osc_trim_pkg.sv
// Shared definitions for the ring oscillator trim calibration controller.
// Holds the trim level range, the controller state encoding, and the
// level -> thermometer trim decode used to drive the 26-bit trim bus.
package ring_osc_trim_pkg;

    localparam int LEVEL_MAX   = 26;
    localparam int NUM_PRIMARY = 13;
    localparam int TRIM_W      = 2 * NUM_PRIMARY;
    localparam int LEVEL_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_DECIDE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Primary bits fill first, then the secondary bank; the result is a
    // plain thermometer code, so each level step adds exactly one stage load.
    function automatic logic [TRIM_W-1:0] level_to_trim(input logic [LEVEL_W-1:0] level);
        logic [TRIM_W-1:0] t;
        t = '0;
        for (int k = 0; k < NUM_PRIMARY; k++) begin
            if (k < int'(level)) t[k] = 1'b1;
            if ((k + NUM_PRIMARY) < int'(level)) t[NUM_PRIMARY + k] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] level);
        return (level > LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : level;
    endfunction

endpackage

// File: rtl/ring_osc_edge_sync.sv
// Synchronizes the divided oscillator into the clk domain and counts its
// edges (rising and falling) with a saturating counter.
// Ports:
//   i_clk, i_resetb : system clock, synchronous active-low reset
//   i_osc_div       : divided oscillator, asynchronous to i_clk
//   i_clear         : zero the counter (has priority over i_enable)
//   i_enable        : count detected edges
//   o_count         : current edge count
module ring_osc_edge_sync #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_resetb,
    input  logic             i_osc_div,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [CNT_W-1:0] r_count;
    logic             w_edge;
    logic             w_sat;

    assign w_edge  = r_sync2 ^ r_hist;
    assign w_sat   = &r_count;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_resetb) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_osc_div;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_enable && w_edge && !w_sat) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ring_osc_trim_cal.sv
// Closed-loop trim calibration for the 13-stage ring oscillator.
// Binary-searches trim levels 0..26 for the fastest level whose edge count
// over a window of i_clk cycles does not exceed i_cfg_target.
//
//   state  | meaning
//   IDLE   | waiting for start; tracks i_cfg_level when manual
//   RST    | holding oscillator reset for RST_CYC cycles
//   SETTLE | trim just changed; counter held clear for SETTLE_CYC cycles
//   MEAS   | counting oscillator edges for max(window,1) cycles
//   DECIDE | one cycle: narrow [lo,hi], pick next level or finish
//   DONE   | result on o_cal_level, o_done high
//
// Ports:
//   i_clk, i_resetb            : system clock, synchronous active-low reset
//   i_start                    : one-cycle calibration request
//   i_cfg_manual, i_cfg_level  : manual trim override and level (clamped to 26)
//   i_cfg_window, i_cfg_target : measurement window and max acceptable count
//   i_osc_div                  : divided oscillator (asynchronous)
//   o_osc_reset, o_trim        : oscillator reset and trim bus
//   o_cal_level, o_meas_count  : current level, last window's edge count
//   o_busy, o_done             : search status
module ring_osc_trim_cal
    import ring_osc_trim_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 16,
    parameter int RST_CYC    = 8
) (
    input  logic               i_clk,
    input  logic               i_resetb,
    input  logic               i_start,
    input  logic               i_cfg_manual,
    input  logic [LEVEL_W-1:0] i_cfg_level,
    input  logic [CNT_W-1:0]   i_cfg_window,
    input  logic [CNT_W-1:0]   i_cfg_target,
    input  logic               i_osc_div,
    output logic               o_osc_reset,
    output logic [TRIM_W-1:0]  o_trim,
    output logic [LEVEL_W-1:0] o_cal_level,
    output logic [CNT_W-1:0]   o_meas_count,
    output logic               o_busy,
    output logic               o_done
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam int TMR_A = (CNT_W > SET_W) ? CNT_W : SET_W;
    localparam int TMR_W = (TMR_A > RST_W) ? TMR_A : RST_W;

    localparam logic [TMR_W-1:0] TMR_RST    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [LEVEL_W-1:0] r_lo;
    logic [LEVEL_W-1:0] w_lo_nxt;
    logic [LEVEL_W-1:0] r_hi;
    logic [LEVEL_W-1:0] w_hi_nxt;
    logic [LEVEL_W-1:0] r_cal_level;
    logic [LEVEL_W-1:0] w_cal_nxt;
    logic               r_osc_reset;
    logic               w_osc_reset_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [CNT_W-1:0]   r_meas_count;
    logic [CNT_W-1:0]   w_meas_nxt;
    logic [TRIM_W-1:0]  r_trim;

    logic [CNT_W-1:0]   w_count;
    logic               w_clear;
    logic               w_enable;
    logic               w_tc;
    logic               w_too_fast;
    logic [TMR_W-1:0]   w_tmr_win;
    logic [TMR_W-1:0]   w_tmr_dec;
    logic [LEVEL_W-1:0] w_lo_dec;
    logic [LEVEL_W-1:0] w_hi_dec;
    logic [LEVEL_W:0]   w_sum;
    logic [LEVEL_W-1:0] w_mid;

    ring_osc_edge_sync #(
        .CNT_W (CNT_W)
    ) u_edge_sync (
        .i_clk     (i_clk),
        .i_resetb  (i_resetb),
        .i_osc_div (i_osc_div),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_count   (w_count)
    );

    // A zero window is stretched to one cycle so MEAS always terminates.
    assign w_tmr_win = (i_cfg_window == '0) ? '0 : TMR_W'(i_cfg_window - CNT_W'(1));
    assign w_tmr_dec = r_timer - TMR_W'(1);
    assign w_tc      = (r_timer == '0);

    // Counting is frozen in DECIDE, so w_count is the finished window.
    assign w_too_fast = (w_count > i_cfg_target);
    assign w_lo_dec   = w_too_fast ? (r_cal_level + LEVEL_W'(1)) : r_lo;
    assign w_hi_dec   = w_too_fast ? r_hi : r_cal_level;
    assign w_sum      = {1'b0, w_lo_dec} + {1'b0, w_hi_dec};
    assign w_mid      = w_sum[LEVEL_W:1];

    always_ff @(posedge i_clk) begin
        if (!i_resetb) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_lo         <= '0;
            r_hi         <= '0;
            r_cal_level  <= '0;
            r_osc_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_meas_count <= '0;
            r_trim       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_lo         <= w_lo_nxt;
            r_hi         <= w_hi_nxt;
            r_cal_level  <= w_cal_nxt;
            r_osc_reset  <= w_osc_reset_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_meas_count <= w_meas_nxt;
            r_trim       <= level_to_trim(r_cal_level);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_lo_nxt        = r_lo;
        w_hi_nxt        = r_hi;
        w_cal_nxt       = r_cal_level;
        w_osc_reset_nxt = r_osc_reset;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_meas_nxt      = r_meas_count;
        w_clear         = 1'b0;
        w_enable        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_cfg_manual) begin
                    w_cal_nxt       = clamp_level(i_cfg_level);
                    w_osc_reset_nxt = 1'b0;
                end else if (i_start) begin
                    w_lo_nxt        = '0;
                    w_hi_nxt        = LEVEL_W'(LEVEL_MAX);
                    w_cal_nxt       = LEVEL_W'(NUM_PRIMARY);
                    w_done_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_osc_reset_nxt = 1'b1;
                    w_timer_nxt     = TMR_RST;
                    w_state_nxt     = ST_RST;
                end
            end
            ST_RST: begin
                if (w_tc) begin
                    w_osc_reset_nxt = 1'b0;
                    w_timer_nxt     = TMR_SETTLE;
                    w_state_nxt     = ST_SETTLE;
                end else begin
                    w_timer_nxt = w_tmr_dec;
                end
            end
            ST_SETTLE: begin
                w_clear = 1'b1;
                if (w_tc) begin
                    w_timer_nxt = w_tmr_win;
                    w_state_nxt = ST_MEAS;
                end else begin
                    w_timer_nxt = w_tmr_dec;
                end
            end
            ST_MEAS: begin
                w_enable = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_DECIDE;
                end else begin
                    w_timer_nxt = w_tmr_dec;
                end
            end
            ST_DECIDE: begin
                w_meas_nxt = w_count;
                w_lo_nxt   = w_lo_dec;
                w_hi_nxt   = w_hi_dec;
                if (w_lo_dec == w_hi_dec) begin
                    w_cal_nxt   = w_lo_dec;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cal_nxt   = w_mid;
                    w_timer_nxt = TMR_SETTLE;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (i_cfg_manual) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (i_start) begin
                    w_lo_nxt        = '0;
                    w_hi_nxt        = LEVEL_W'(LEVEL_MAX);
                    w_cal_nxt       = LEVEL_W'(NUM_PRIMARY);
                    w_done_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_osc_reset_nxt = 1'b1;
                    w_timer_nxt     = TMR_RST;
                    w_state_nxt     = ST_RST;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_osc_reset  = r_osc_reset;
    assign o_trim       = r_trim;
    assign o_cal_level  = r_cal_level;
    assign o_meas_count = r_meas_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Directed bench for ring_osc_trim_cal. A behavioural oscillator toggles
// osc_div every 4+L clk cycles (L = ones in the trim bus) after a 13-cycle
// start-up delay following osc_reset release. A second instance with
// CNT_W=4 sees an osc_div that toggles every cycle.
module tb_ring_osc_trim_cal;
    import ring_osc_trim_pkg::*;

    logic        clk;
    logic        resetb;

    logic        start;
    logic        cfg_manual;
    logic [4:0]  cfg_level;
    logic [15:0] cfg_window;
    logic [15:0] cfg_target;
    logic        osc_div;
    logic        osc_reset;
    logic [25:0] trim;
    logic [4:0]  cal_level;
    logic [15:0] meas_count;
    logic        busy;
    logic        done;

    logic        start2;
    logic [3:0]  cfg_window2;
    logic [3:0]  cfg_target2;
    logic        osc_div2;
    logic        osc_reset2;
    logic [25:0] trim2;
    logic [4:0]  cal_level2;
    logic [3:0]  meas_count2;
    logic        busy2;
    logic        done2;

    int n_checks;
    int n_fail;

    ring_osc_trim_cal #(.CNT_W(16), .SETTLE_CYC(16), .RST_CYC(8)) dut (
        .i_clk        (clk),
        .i_resetb     (resetb),
        .i_start      (start),
        .i_cfg_manual (cfg_manual),
        .i_cfg_level  (cfg_level),
        .i_cfg_window (cfg_window),
        .i_cfg_target (cfg_target),
        .i_osc_div    (osc_div),
        .o_osc_reset  (osc_reset),
        .o_trim       (trim),
        .o_cal_level  (cal_level),
        .o_meas_count (meas_count),
        .o_busy       (busy),
        .o_done       (done)
    );

    ring_osc_trim_cal #(.CNT_W(4), .SETTLE_CYC(4), .RST_CYC(2)) dut2 (
        .i_clk        (clk),
        .i_resetb     (resetb),
        .i_start      (start2),
        .i_cfg_manual (1'b0),
        .i_cfg_level  (5'd0),
        .i_cfg_window (cfg_window2),
        .i_cfg_target (cfg_target2),
        .i_osc_div    (osc_div2),
        .o_osc_reset  (osc_reset2),
        .o_trim       (trim2),
        .o_cal_level  (cal_level2),
        .o_meas_count (meas_count2),
        .o_busy       (busy2),
        .o_done       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator models, updated on the falling edge.
    initial begin
        int cnt;
        int su;
        int per;
        osc_div  = 1'b0;
        osc_div2 = 1'b0;
        cnt = 0;
        su  = 13;
        forever begin
            @(negedge clk);
            osc_div2 = ~osc_div2;
            per = 4 + $countones(trim);
            if (osc_reset) begin
                osc_div = 1'b0;
                cnt = 0;
                su  = 13;
            end else if (su > 0) begin
                su = su - 1;
            end else if (cnt >= per - 1) begin
                osc_div = ~osc_div;
                cnt = 0;
            end else begin
                cnt = cnt + 1;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int maxc, inout int decides, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (dut.r_state == ST_DECIDE) decides++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done2(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL reset_osc_reset: got %b expected 1", osc_reset); end
        n_checks++; if (trim !== 26'h0) begin n_fail++; $display("FAIL reset_trim: got %h expected 0", trim); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (cal_level !== 5'd0) begin n_fail++; $display("FAIL reset_cal_level: got %0d expected 0", cal_level); end
        n_checks++; if (meas_count !== 16'd0) begin n_fail++; $display("FAIL reset_meas_count: got %0d expected 0", meas_count); end
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL reset_osc_reset_hold: got %b expected 1", osc_reset); end
    endtask

    task automatic test_manual();
        cfg_manual = 1'b1;
        cfg_level  = 5'd20;
        repeat (3) @(negedge clk);
        n_checks++; if (cal_level !== 5'd20) begin n_fail++; $display("FAIL manual_cal_level: got %0d expected 20", cal_level); end
        n_checks++; if (trim !== 26'h00FFFFF) begin n_fail++; $display("FAIL manual_trim: got %h expected 00fffff", trim); end
        n_checks++; if (osc_reset !== 1'b0) begin n_fail++; $display("FAIL manual_osc_reset: got %b expected 0", osc_reset); end
        cfg_level = 5'd31;
        repeat (2) @(negedge clk);
        n_checks++; if (cal_level !== 5'd26) begin n_fail++; $display("FAIL manual_clamp_level: got %0d expected 26", cal_level); end
        n_checks++; if (trim !== 26'h3FFFFFF) begin n_fail++; $display("FAIL manual_clamp_trim: got %h expected 3ffffff", trim); end
        pulse_start();
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL manual_start_ignored: busy got %b expected 0", busy); end
        cfg_manual = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int decides;
        bit ok;
        decides = 0;
        cfg_window = 16'd270;
        cfg_target = 16'd15;
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nominal_busy: got %b expected 1", busy); end
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL nominal_osc_reset: got %b expected 1", osc_reset); end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dut.r_state == ST_DECIDE) decides++;
        end
        // second window is in progress: a start here must be ignored
        pulse_start();
        wait_done(5000, decides, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nominal_timeout: done got %b expected 1", done); end
        n_checks++; if (cal_level !== 5'd13) begin n_fail++; $display("FAIL nominal_cal_level: got %0d expected 13", cal_level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_end: got %b expected 0", busy); end
        n_checks++; if (decides !== 4) begin n_fail++; $display("FAIL nominal_decides: got %0d expected 4", decides); end
        @(negedge clk);
        n_checks++; if (trim !== 26'h0001FFF) begin n_fail++; $display("FAIL nominal_trim: got %h expected 0001fff", trim); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nominal_done_hold: got %b expected 1", done); end
    endtask

    task automatic test_endpoints();
        int decides;
        bit ok;
        decides = 0;
        cfg_target = 16'hFFFF;
        pulse_start();
        wait_done(5000, decides, ok);
        @(negedge clk);
        n_checks++; if (!ok || cal_level !== 5'd0) begin n_fail++; $display("FAIL endpoint_slow_level: got %0d expected 0", cal_level); end
        n_checks++; if (trim !== 26'h0) begin n_fail++; $display("FAIL endpoint_slow_trim: got %h expected 0", trim); end
        cfg_target = 16'd0;
        pulse_start();
        wait_done(5000, decides, ok);
        @(negedge clk);
        n_checks++; if (!ok || cal_level !== 5'd26) begin n_fail++; $display("FAIL endpoint_fast_level: got %0d expected 26", cal_level); end
        n_checks++; if (trim !== 26'h3FFFFFF) begin n_fail++; $display("FAIL endpoint_fast_trim: got %h expected 3ffffff", trim); end
        cfg_target = 16'd15;
    endtask

    task automatic test_abort();
        int decides;
        bit ok;
        bit found;
        decides = 0;
        found = 1'b0;
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dut.r_state == ST_DECIDE) decides++;
            if (decides == 2 && dut.r_state == ST_MEAS) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL abort_third_meas: decides got %0d expected 2", decides); end
        repeat (50) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        n_checks++; if (osc_reset !== 1'b1) begin n_fail++; $display("FAIL abort_osc_reset: got %b expected 1", osc_reset); end
        n_checks++; if (trim !== 26'h0) begin n_fail++; $display("FAIL abort_trim: got %h expected 0", trim); end
        n_checks++; if (cal_level !== 5'd0) begin n_fail++; $display("FAIL abort_cal_level: got %0d expected 0", cal_level); end
        n_checks++; if (meas_count !== 16'd0) begin n_fail++; $display("FAIL abort_meas_count: got %0d expected 0", meas_count); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_status: busy/done got %b%b expected 00", busy, done); end
        resetb = 1'b1;
        @(negedge clk);
        decides = 0;
        pulse_start();
        wait_done(5000, decides, ok);
        n_checks++; if (!ok || cal_level !== 5'd13) begin n_fail++; $display("FAIL abort_rerun_level: got %0d expected 13", cal_level); end
        n_checks++; if (decides !== 4) begin n_fail++; $display("FAIL abort_rerun_decides: got %0d expected 4", decides); end
        @(negedge clk);
        n_checks++; if (trim !== 26'h0001FFF) begin n_fail++; $display("FAIL abort_rerun_trim: got %h expected 0001fff", trim); end
    endtask

    task automatic test_saturation();
        bit ok;
        cfg_window2 = 4'd15;
        cfg_target2 = 4'd15;
        pulse_start2();
        wait_done2(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: done2 got %b expected 1", done2); end
        n_checks++; if (meas_count2 !== 4'd15) begin n_fail++; $display("FAIL sat_meas_count: got %0d expected 15", meas_count2); end
        n_checks++; if (cal_level2 !== 5'd0) begin n_fail++; $display("FAIL sat_cal_level: got %0d expected 0", cal_level2); end
    endtask

    task automatic test_zero_window();
        bit ok;
        cfg_window2 = 4'd0;
        cfg_target2 = 4'd0;
        pulse_start2();
        wait_done2(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_window_timeout: done2 got %b expected 1", done2); end
        n_checks++; if (meas_count2 !== 4'd1) begin n_fail++; $display("FAIL zero_window_meas: got %0d expected 1", meas_count2); end
        n_checks++; if (cal_level2 !== 5'd26) begin n_fail++; $display("FAIL zero_window_level: got %0d expected 26", cal_level2); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        resetb      = 1'b0;
        start       = 1'b0;
        cfg_manual  = 1'b0;
        cfg_level   = 5'd0;
        cfg_window  = 16'd270;
        cfg_target  = 16'd15;
        start2      = 1'b0;
        cfg_window2 = 4'd15;
        cfg_target2 = 4'd15;

        test_reset();
        test_manual();
        test_nominal();
        test_endpoints();
        test_abort();
        test_saturation();
        test_zero_window();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
